// File: rtl/instr_sequencer.sv
// Program sequencer: loadable opcode+literal memory, stepped by a program counter,
// issuing one opcode per clock to the control unit until HALT, illegal opcode, end or abort.
module instr_sequencer #(
  parameter int unsigned DEPTH_W = 4,
  parameter int unsigned LIT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en_i,
  input  logic [DEPTH_W-1:0] load_addr_i,
  input  logic [LIT_W+4:0]   load_data_i,
  output logic               load_ready_o,
  input  logic               start_i,
  input  logic               hold_i,
  input  logic               abort_i,
  output logic [4:0]         address_o,
  output logic [LIT_W-1:0]   literal_o,
  output logic               issue_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [DEPTH_W-1:0] pc_o
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned WORD_W = OP_W + LIT_W;
  localparam int unsigned DEPTH  = 1 << DEPTH_W;

  localparam logic [OP_W-1:0]    OP_HALT     = 5'h1F;
  localparam logic [OP_W-1:0]    OP_EXEC_MAX = 5'h18;
  localparam logic [DEPTH_W-1:0] PC_LAST     = DEPTH_W'(DEPTH - 1);
  localparam logic [WORD_W-1:0]  HALT_WORD   = {OP_HALT, {LIT_W{1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]    address_q, address_d;
  logic [LIT_W-1:0]   literal_q, literal_d;
  logic               issue_q, issue_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               mem_we_c;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [WORD_W-1:0]  fetch_word_c;
  logic [OP_W-1:0]    fetch_op_c;
  logic [LIT_W-1:0]   fetch_lit_c;

  // Combinational fetch of the word under the program counter
  assign fetch_word_c = mem_q[pc_q];
  assign fetch_op_c   = fetch_word_c[WORD_W-1:LIT_W];
  assign fetch_lit_c  = fetch_word_c[LIT_W-1:0];

  // Next-state, next-pc and issue/termination decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    address_d = '0;
    literal_d = '0;
    issue_d   = 1'b0;
    done_d    = 1'b0;
    error_d   = error_q;
    mem_we_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_we_c = load_en_i;
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end else if (!hold_i) begin
          if (fetch_op_c <= OP_EXEC_MAX) begin
            issue_d   = 1'b1;
            address_d = fetch_op_c;
            literal_d = fetch_lit_c;
            // Last word terminates normally instead of wrapping
            if (pc_q == PC_LAST) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
              pc_d    = '0;
            end else begin
              pc_d = pc_q + DEPTH_W'(1);
            end
          end else if (fetch_op_c == OP_HALT) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pc_d    = '0;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
            pc_d    = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      address_q <= '0;
      literal_q <= '0;
      issue_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      address_q <= address_d;
      literal_q <= literal_d;
      issue_q   <= issue_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Program memory; reset refills every word with HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= HALT_WORD;
      end
    end else if (mem_we_c) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  assign address_o    = address_q;
  assign literal_o    = literal_q;
  assign issue_o      = issue_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign pc_o         = pc_q;
  assign busy_o       = (state_q == ST_RUN);
  assign load_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a run-level model predicts the full per-cycle trace of each
// program run from the loaded words and the hold/abort schedule; literals pin the model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [12:0] load_data = '0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  address;
  logic [7:0]  literal;
  logic        issue, busy, done, error;
  logic [3:0]  pc;

  instr_sequencer #(.DEPTH_W(4), .LIT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (load_en),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .start_i      (start),
    .hold_i       (hold),
    .abort_i      (abort),
    .address_o    (address),
    .literal_o    (literal),
    .issue_o      (issue),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .pc_o         (pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       issue;
    logic [4:0] addr;
    logic [7:0] lit;
    logic       done;
    logic       err;
    logic       busy;
    logic       lr;
    logic [3:0] pc;
  } rec_t;

  int          checks = 0;
  int          failures = 0;
  bit          cmp_en = 1'b0;

  logic [63:0] hold_mask = '0;
  int          abort_at = 0;
  rec_t        trace[$];
  rec_t        cur;
  logic [12:0] m_mem [16];
  logic        m_err;

  int          n_iss, n_done, n_busy, done_off;
  logic [4:0]  iss_addr [32];
  logic [7:0]  iss_lit  [32];

  function automatic rec_t mk(input logic is, input logic [4:0] a, input logic [7:0] l,
                              input logic d, input logic e, input logic b, input logic [3:0] p);
    rec_t r;
    r.issue = is; r.addr = a; r.lit = l; r.done = d; r.err = e;
    r.busy = b; r.lr = ~b; r.pc = p;
    return r;
  endfunction

  // Whole-run timeline: n leading executable words, then the word that ends the run
  function automatic void build_trace();
    int n;
    int k;
    logic [12:0] w;
    trace.delete();
    trace.push_back(mk(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b1, 4'h0));
    n = 0;
    while (n < 16 && m_mem[n][12:8] <= 5'h18) n++;
    k = 0;
    for (int c = 1; c < 64; c++) begin
      if (c == abort_at) begin
        trace.push_back(mk(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0));
        return;
      end
      if (hold_mask[c]) begin
        trace.push_back(mk(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b1, 4'(k)));
        continue;
      end
      w = m_mem[k];
      if (k < n) begin
        if (k == 15) begin
          trace.push_back(mk(1'b1, w[12:8], w[7:0], 1'b1, 1'b0, 1'b0, 4'h0));
          return;
        end
        trace.push_back(mk(1'b1, w[12:8], w[7:0], 1'b0, 1'b0, 1'b1, 4'(k + 1)));
        k++;
        continue;
      end
      if (w[12:8] == 5'h1F) begin
        trace.push_back(mk(1'b0, 5'h0, 8'h0, 1'b1, 1'b0, 1'b0, 4'h0));
      end else begin
        trace.push_back(mk(1'b0, 5'h0, 8'h0, 1'b0, 1'b1, 1'b0, 4'h0));
        m_err = 1'b1;
      end
      return;
    end
  endfunction

  // Model: replays a precomputed run, otherwise tracks loads and start while idle
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        trace.delete();
        for (int i = 0; i < 16; i++) m_mem[i] = 13'h1F00;
        m_err = 1'b0;
        cur = mk(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      end else if (trace.size() != 0) begin
        cur = trace.pop_front();
      end else begin
        if (load_en) m_mem[load_addr] = load_data;
        if (start) begin
          m_err = 1'b0;
          build_trace();
          cur = trace.pop_front();
        end else begin
          cur = mk(1'b0, 5'h0, 8'h0, 1'b0, m_err, 1'b0, 4'h0);
        end
      end
    end
  end

  // Cycle compare against the model
  initial begin
    rec_t act;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        act.issue = issue; act.addr = address; act.lit = literal; act.done = done;
        act.err = error; act.busy = busy; act.lr = load_ready; act.pc = pc;
        checks++;
        if (act !== cur) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t act=%h exp=%h", $time, act, cur);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [12:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Start a run and drive hold/abort/load/reset at cycle offsets after the start edge
  task automatic run_prog(input logic [63:0] hmask, input int abort_c, input int load_c,
                          input logic [3:0] la, input logic [12:0] ld, input int rst_c,
                          input int ncyc);
    hold_mask = hmask;
    abort_at  = abort_c;
    n_iss = 0; n_done = 0; n_busy = 0; done_off = -1;
    @(negedge clk);
    start = 1'b1;
    if (load_c == 0) begin
      load_en = 1'b1; load_addr = la; load_data = ld;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (issue) begin
        if (n_iss < 32) begin
          iss_addr[n_iss] = address;
          iss_lit[n_iss]  = literal;
        end
        n_iss++;
      end
      if (done) begin
        n_done++;
        if (done_off < 0) done_off = c - 1;
      end
      if (busy) n_busy++;
      start   = 1'b0;
      load_en = (c == load_c);
      load_addr = la;
      load_data = ld;
      hold    = hmask[c];
      abort   = (c == abort_c);
      if (c == rst_c) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", 32'({address, literal, issue, busy, done, error, pc}), 32'h0);
        chk("rst_load_ready", 32'(load_ready), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0; load_en = 1'b0; hold = 1'b0; abort = 1'b0;
    chk("run_ended_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t checks=%0d", $time, checks);
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #20;
    @(negedge clk);
    chk("reset_issue", 32'(issue), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ready", 32'(load_ready), 32'h1);
    chk("reset_pc_err_done", 32'({pc, error, done}), 32'h0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Empty memory: HALT at word 0
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("empty_issues", 32'(n_iss), 32'd0);
    chk("empty_done_off", 32'(done_off), 32'd1);
    chk("empty_busy_cycles", 32'(n_busy), 32'd1);
    chk("empty_error", 32'(error), 32'h0);

    // Three executable words then HALT
    load_word(4'd0, {5'h00, 8'h12});
    load_word(4'd1, {5'h07, 8'h34});
    load_word(4'd2, {5'h18, 8'hFF});
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("prog_issues", 32'(n_iss), 32'd3);
    chk("prog_addr", 32'({iss_addr[0], iss_addr[1], iss_addr[2]}), 32'({5'h00, 5'h07, 5'h18}));
    chk("prog_lit", 32'({iss_lit[0], iss_lit[1], iss_lit[2]}), 32'h1234FF);
    chk("prog_done_off", 32'(done_off), 32'd4);
    chk("prog_pc_ready", 32'({pc, load_ready}), 32'h1);

    // Two hold cycles after the first issue
    run_prog(64'hC, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("hold_issues", 32'(n_iss), 32'd3);
    chk("hold_second_addr", 32'(iss_addr[1]), 32'h07);
    chk("hold_done_off", 32'(done_off), 32'd6);

    // Illegal opcode at word 1, then a clean start clears error
    load_word(4'd1, {5'h1A, 8'h00});
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("illegal_issues", 32'(n_iss), 32'd1);
    chk("illegal_no_done", 32'(n_done), 32'd0);
    chk("illegal_error", 32'(error), 32'h1);
    load_word(4'd1, {5'h07, 8'h34});
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("restart_error_clear", 32'(error), 32'h0);
    chk("restart_done_off", 32'(done_off), 32'd4);

    // Full memory of executable words: no wrap past the last word
    for (int i = 0; i < 16; i++) load_word(4'(i), {5'h05, 8'(i)});
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 22);
    chk("full_issues", 32'(n_iss), 32'd16);
    chk("full_done_off", 32'(done_off), 32'd16);
    chk("full_last_lit", 32'(iss_lit[15]), 32'd15);

    // Abort mid-run
    run_prog(64'h0, 5, -1, 4'h0, 13'h0, 0, 12);
    chk("abort_issues", 32'(n_iss), 32'd4);
    chk("abort_no_done", 32'(n_done), 32'd0);

    // Load attempt while running is ignored
    run_prog(64'h0, 0, 3, 4'd2, {5'h01, 8'hAA}, 0, 22);
    chk("runload_issues", 32'(n_iss), 32'd16);
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 22);
    chk("runload_word2", 32'({iss_addr[2], iss_lit[2]}), 32'({5'h05, 8'h02}));

    // Reset mid-run refills memory with HALT
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 4, 12);
    run_prog(64'h0, 0, -1, 4'h0, 13'h0, 0, 12);
    chk("postrst_issues", 32'(n_iss), 32'd0);
    chk("postrst_done_off", 32'(done_off), 32'd1);

    // Load and start in the same cycle: first fetch sees the new word
    run_prog(64'h0, 0, 0, 4'd0, {5'h03, 8'h44}, 0, 12);
    chk("samecyc_issues", 32'(n_iss), 32'd1);
    chk("samecyc_word", 32'({iss_addr[0], iss_lit[0]}), 32'({5'h03, 8'h44}));
    chk("samecyc_done_off", 32'(done_off), 32'd2);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that drives the 5-bit opcode input of the datapath control unit. It holds a small loadable program memory of opcode+literal words, steps a program counter, and issues one opcode per clock with a qualifying strobe. It stops on a HALT word, an illegal opcode, the end of memory, or an abort. It sits between the host/test harness (program load, start) and the control unit/datapath (address, literal).

## Interface
- DEPTH_W, 4, program counter width; program depth is 2^DEPTH_W words
- LIT_W, 8, literal field width; instruction word is 5+LIT_W bits, opcode in the upper 5 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- load_en  in  1  write program word; accepted only while load_ready=1
- load_addr  in  DEPTH_W  program word index
- load_data  in  5+LIT_W  {opcode, literal}
- load_ready  out  1  1 when state is IDLE
- start  in  1  begin execution at word 0; sampled only in IDLE
- hold  in  1  stall in RUN; pc frozen, no issue
- abort  in  1  terminate RUN immediately
- address  out  5  opcode to the control unit; 0 whenever issue=0
- literal  out  LIT_W  literal of the issued word; 0 whenever issue=0
- issue  out  1  address/literal valid this cycle
- busy  out  1  1 in RUN
- done  out  1  one-cycle pulse on normal termination
- error  out  1  sticky illegal-opcode flag; cleared by start
- pc  out  DEPTH_W  current program counter

## Operation
- Opcode classes: 0x00–0x18 executable (issued); 0x1F HALT; 0x19–0x1E illegal.
- Memory: 2^DEPTH_W registered words; reset fills every word with {5'h1F, 0} (HALT). Read is combinational from pc.
- States: IDLE, RUN.
- IDLE: load_en=1 writes mem[load_addr]<=load_data. start=1 -> RUN, pc<=0, error<=0. load_en and start in the same cycle: write occurs and start is accepted; the written word is visible to the first fetch.
- RUN, abort=1 (highest priority): -> IDLE, issue<=0, no done, pc<=0, error unchanged.
- RUN, hold=1: issue<=0, address/literal<=0, pc held.
- RUN, fetched executable: address<=opcode, literal<=lit, issue<=1. If pc==2^DEPTH_W-1, the word is issued, then -> IDLE with done<=1 and pc<=0 (no wrap to 0). Otherwise pc<=pc+1.
- RUN, fetched HALT: issue<=0, done<=1, -> IDLE, pc<=0.
- RUN, fetched illegal: issue<=0, error<=1, no done, -> IDLE, pc<=0.
- start or load_en in RUN: ignored. load_ready=0 in RUN.
- Reset mid-run: immediate return to IDLE. All outputs go to reset values and memory is refilled with HALT.

## Timing
- Reset values: address=0, literal=0, issue=0, busy=0, done=0, error=0, pc=0, load_ready=1, state IDLE.
- address, literal, issue, done, error are registered; busy and load_ready decode from state.
- start sampled at edge N: busy=1 after N; first issue after edge N+1. Start-to-first-issue latency is 2 cycles.
- Throughput: one opcode per cycle while hold=0.
- Program of n executable words followed by HALT, with no hold: issue high for edges N+1..N+n. done pulses after edge N+n+1, in the same cycle that busy drops.
- Each hold cycle delays all subsequent issues and done by one cycle.
- done and error are never both set by the same termination.

## Test plan
- Reset, then start without loading -> busy for 1 cycle, done pulse 2 cycles after start, issue never high, error=0.
- Load [0x00/0x12, 0x07/0x34, 0x18/0xFF, HALT] and start -> issue high for 3 consecutive cycles with address 0x00, 0x07, 0x18 and literal 0x12, 0x34, 0xFF. done pulses on the next cycle, then pc=0 and load_ready=1.
- Same program with hold=1 for 2 cycles after the first issue -> issue low for 2 cycles, then 0x07 and 0x18 issue. done is delayed by exactly 2 cycles.
- Word 1 = 0x1A -> 0x00 issued, then error=1, done=0, IDLE. A following start clears error.
- Fill all 16 words with 0x05 -> 16 issues, done after the 16th, no 17th issue. abort during a second run -> issue low next cycle, no done, busy=0.
- load_en during RUN at word 2 -> memory unchanged (verified by rerun). rst_n low mid-run -> all outputs 0 immediately; memory is HALT-filled afterwards.
